// File: rtl/cv32e40p_uart_tx.sv
// Bus-mapped UART transmitter: byte stores to TXDATA are queued in a FIFO and sent 8N1 (8E1 with UART_TX_PARITY_EN).
// Pushes stall (gnt low) while the FIFO is full; the line starts a frame one cycle after the push.
module cv32e40p_uart_tx #(
    parameter int unsigned CLK_FREQ_HZ = 20_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        uart_tx_o,
    output logic        busy_o
);

    localparam int unsigned DIV = CLK_FREQ_HZ / BAUD;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] RELOAD   = CW'(DIV - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_PRESENT = 1'b1;
`else
    localparam logic PAR_PRESENT = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            rvalid_q;
    logic [31:0]     rdata_q, rdata_d;

    logic sel, off, wr_tx, full, empty, gnt, push, pop, bit_end;
    logic [7:0]  head, cnt8;
    logic [31:0] status;
    logic        unused_bits;

    assign sel     = data_req_i && (data_addr_i[31:3] == BASE_ADDR[31:3]);
    assign off     = data_addr_i[2];
    assign wr_tx   = data_we_i && !off && data_be_i[0];
    // Full comes from the registered count only, so a push never rides on a same-cycle pop.
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign gnt     = sel && !(wr_tx && full);
    assign push    = sel && wr_tx && !full;
    assign head    = mem_q[rd_ptr_q];
    assign bit_end = (cnt_q == '0);
    assign cnt8    = 8'(count_q);
    assign status  = {16'h0, cnt8, 4'h0, PAR_PRESENT, (state_q != S_IDLE), empty, full};
    assign unused_bits = ^{data_addr_i[1:0], data_be_i[3:1], data_wdata_i[31:8]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: pop = !empty;
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = RELOAD;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = RELOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = RELOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!empty) pop = 1'b1;
                    else        state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A pop from IDLE or the end of STOP both launch the next frame straight into START.
        if (pop) begin
            shift_d = head;
            state_d = S_START;
            cnt_d   = RELOAD;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
        end
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        rdata_d = (gnt && !data_we_i && off) ? status : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_wdata_i[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_d;
            rvalid_q <= gnt;
            rdata_q  <= rdata_d;
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign uart_tx_o     = tx_q;
    assign busy_o        = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_cv32e40p_uart_tx.sv
// Bench for cv32e40p_uart_tx: bus-op table, line waveform checks, and a serial monitor fed by a byte scoreboard.
module tb_cv32e40p_uart_tx;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [31:0] PB = 32'h8;
`else
    localparam int NB = 10;
    localparam logic [31:0] PB = 32'h0;
`endif
    localparam int FRAME = NB * DIV;

    logic        clk, rst_n;
    logic        data_req_i, data_we_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic [3:0]  data_be_i;
    logic        data_gnt_o, data_rvalid_o, uart_tx_o, busy_o;
    logic [31:0] data_rdata_o;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rst_epoch = 0;
    logic [7:0] sb[$];
    time  starts[$];

    cv32e40p_uart_tx #(
        .CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(8), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .uart_tx_o(uart_tx_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_epoch <= rst_epoch + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Decodes each frame at mid-bit and checks it against the scoreboard; frames cut by reset are discarded.
    initial begin : monitor
        int ep;
        logic s0, sp, pb;
        logic [7:0] d, e;
        forever begin
            @(negedge uart_tx_o);
            ep = rst_epoch;
            starts.push_back($time);
            repeat (5) @(negedge clk);
            s0 = uart_tx_o;
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clk);
                d[i] = uart_tx_o;
            end
            pb = 1'b0;
            if (NB == 11) begin
                repeat (DIV) @(negedge clk);
                pb = uart_tx_o;
            end
            repeat (DIV) @(negedge clk);
            sp = uart_tx_o;
            if (ep == rst_epoch) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mon_unexpected: got frame %h required no frame", d);
                end else begin
                    e = sb.pop_front();
                    chk("mon_start", s0, 0);
                    chk("mon_data", d, e);
                    if (NB == 11) chk("mon_parity", pb, ^e);
                    chk("mon_stop", sp, 1);
                end
            end
        end
    end

    task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output logic g, output logic rv_pre,
                       output logic rv, output logic [31:0] rd);
        @(negedge clk);
        data_req_i = 1'b1; data_we_i = we; data_addr_i = addr; data_be_i = be; data_wdata_i = wd;
        #1 g = data_gnt_o;
        rv_pre = data_rvalid_o;
        @(posedge clk);
        if (g && we && addr == BASE && be[0]) sb.push_back(wd[7:0]);
        @(negedge clk);
        data_req_i = 1'b0;
        rv = data_rvalid_o;
        rd = data_rdata_o;
    endtask

    task automatic wr(input logic [7:0] b, input string nm);
        logic g, rp, rv;
        logic [31:0] rd;
        bus(1'b1, BASE, 4'b0001, {24'h0, b}, g, rp, rv, rd);
        chk(nm, g, 1);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while ((sb.size() != 0 || busy_o) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_sb"}, sb.size(), 0);
        chk({nm, "_busy"}, busy_o, 0);
    endtask

    // Called right after a write returns (the negedge after its grant edge).
    task automatic wave(input logic [7:0] b, input string nm);
        int bad = 0;
        int bi;
        logic e;
        chk({nm, "_pre"}, uart_tx_o, 1);
        for (int c = 0; c <= FRAME; c++) begin
            @(negedge clk);
            bi = c / DIV;
            if (c == FRAME)      e = 1'b1;
            else if (bi == 0)    e = 1'b0;
            else if (bi <= 8)    e = b[bi-1];
            else if (bi == 9 && NB == 11) e = ^b;
            else                 e = 1'b1;
            if (uart_tx_o !== e) bad++;
            if (c == FRAME - 1) chk({nm, "_busy_last"}, busy_o, 1);
            if (c == FRAME)     chk({nm, "_busy_drop"}, busy_o, 0);
        end
        chk({nm, "_wave"}, bad, 0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        exp_gnt;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    initial begin
        vec_t tv[6];
        logic g, rp, rv, got;
        logic [31:0] rd;
        int gcyc0, gcyc8, t10, n, badgap;

        data_req_i = 0; data_we_i = 0; data_addr_i = 0; data_be_i = 0; data_wdata_i = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", uart_tx_o, 1);
        chk("rst_rdata", data_rdata_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_tx", uart_tx_o, 1);
        chk("t1_busy", busy_o, 0);
        chk("t1_rvalid", data_rvalid_o, 0);

        tv[0] = '{1'b0, BASE + 4, 4'hF, 32'h0,         1'b1, 1'b1, 32'h2 | PB};
        tv[1] = '{1'b0, BASE,     4'hF, 32'h0,         1'b1, 1'b1, 32'h0};
        tv[2] = '{1'b1, BASE,     4'b0010, 32'hAA,     1'b1, 1'b0, 32'h0};
        tv[3] = '{1'b1, BASE + 4, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
        tv[4] = '{1'b0, BASE + 8, 4'hF, 32'h0,         1'b0, 1'b0, 32'h0};
        tv[5] = '{1'b0, BASE + 4, 4'hF, 32'h0,         1'b1, 1'b1, 32'h2 | PB};
        for (int i = 0; i < 6; i++) begin
            bus(tv[i].we, tv[i].addr, tv[i].be, tv[i].wd, g, rp, rv, rd);
            chk($sformatf("tv%0d_gnt", i), g, tv[i].exp_gnt);
            chk($sformatf("tv%0d_rv_pre", i), rp, 0);
            chk($sformatf("tv%0d_rvalid", i), rv, tv[i].exp_gnt);
            if (tv[i].chk_rd) chk($sformatf("tv%0d_rdata", i), rd, tv[i].exp_rd);
            @(negedge clk);
            chk($sformatf("tv%0d_rv_drop", i), data_rvalid_o, 0);
        end
        chk("tv_busy", busy_o, 0);

        wr(8'h55, "t2_gnt");
        wave(8'h55, "t2");
        wait_idle(50, "t2");

        starts.delete();
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = BASE; data_be_i = 4'b0001;
        gcyc0 = 0; gcyc8 = 0;
        for (int k = 0; k < 9; k++) begin
            data_wdata_i = 32'hC0 + k;
            #1 g = data_gnt_o;
            chk($sformatf("t3_gnt%0d", k), g, 1);
            @(posedge clk);
            if (g) sb.push_back(8'hC0 + 8'(k));
            @(negedge clk);
            if (k == 0) gcyc0 = cyc;
            if (k == 8) gcyc8 = cyc;
        end
        chk("t3_consecutive", gcyc8 - gcyc0, 8);
        data_we_i = 1'b0; data_addr_i = BASE + 4;
        #1 chk("t3_st_gnt", data_gnt_o, 1);
        @(posedge clk);
        @(negedge clk);
        chk("t3_st_rvalid", data_rvalid_o, 1);
        chk("t3_status_full", data_rdata_o, 32'h0805 | PB);
        data_we_i = 1'b1; data_addr_i = BASE; data_wdata_i = 32'hC9;
        got = 1'b0; n = 0;
        while (!got && n < 400) begin
            #1 g = data_gnt_o;
            @(posedge clk);
            if (g) begin
                sb.push_back(8'hC9);
                got = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        t10 = cyc;
        data_req_i = 1'b0;
        chk("t3_gnt10", got, 1);
        chk("t3_gnt10_edge", t10 - gcyc0, FRAME + 2);
        wait_idle(12 * FRAME, "t3");
        chk("t3_frames", starts.size(), 10);
        badgap = 0;
        for (int i = 1; i < starts.size(); i++)
            if (starts[i] - starts[i-1] != FRAME * 10) badgap++;
        chk("t3_gaps", badgap, 0);

        wr(8'hA3, "t5_gnt0");
        wr(8'h11, "t5_gnt1");
        wr(8'h22, "t5_gnt2");
        wr(8'h33, "t5_gnt3");
        repeat (35) @(negedge clk);
        chk("t5_mid_low", uart_tx_o, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", uart_tx_o, 1);
        chk("t5_rst_busy", busy_o, 0);
        chk("t5_rst_rvalid", data_rvalid_o, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        bus(1'b0, BASE + 4, 4'hF, 32'h0, g, rp, rv, rd);
        chk("t5_status", rd, 32'h2 | PB);
        wr(8'h0F, "t5_gnt_0f");
        wave(8'h0F, "t5");
        wait_idle(50, "t5");

`ifdef UART_TX_PARITY_EN
        wr(8'h07, "t6_gnt07");
        wave(8'h07, "t6a");
        wait_idle(50, "t6a");
        wr(8'h03, "t6_gnt03");
        wave(8'h03, "t6b");
        wait_idle(50, "t6b");
`endif

        repeat (5) @(negedge clk);
        chk("end_tx", uart_tx_o, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
